rgb_sram_writer: RTL
====================

// Module: rgb_sram_writer
// PURPOSE
//  Final stage of milestone 1. It accepts a stream of 8-bit R,G,B pixels from the colour-space-conversion datapath.
//  Each pair of pixels is packed into three 16-bit words: {R0,G0}, {B0,R1}, {G1,B1}.
//  The words are written sequentially into the RGB region of external SRAM, which the VGA/PPM readers use.
//  Every write to that region passes through this block.
// PARAMETERS
//  BASE_ADDR   146944  first SRAM word address of the RGB region
//  NUM_PIXELS  76800   pixels per frame (320x240); must be even; NUM_WORDS = 3*NUM_PIXELS/2 = 115200
//  FIFO_DEPTH  4       word FIFO entries between the packer and the SRAM port; minimum 2
// PORTS
//  Clock            in   1   system clock (50 MHz)
//  Reset            in   1   asynchronous, active-high reset
//  start            in   1   one-cycle pulse that begins a frame; honoured only in S_IDLE
//  pix_valid        in   1   R/G/B inputs hold a pixel
//  pix_ready        out  1   block accepts the pixel this cycle
//  pix_r            in   8   red
//  pix_g            in   8   green
//  pix_b            in   8   blue
//  sram_req         out  1   block requests the SRAM port (FIFO not empty)
//  sram_grant       in   1   top-level arbiter grants the SRAM port this cycle
//  SRAM_address     out  18  write address (registered)
//  SRAM_write_data  out  16  write data (registered)
//  SRAM_we_n        out  1   active-low write strobe (registered)
//  busy             out  1   high in every state except S_IDLE
//  done             out  1   one-cycle pulse after the final word is written
// BEHAVIOUR
//  Reset
//  - All state registers clear immediately: state=S_IDLE, FIFO empty, pixel count=0, write count=0, odd-phase flag=0.
//  - Outputs: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, sram_req=0, pix_ready=0, busy=0, done=0.
//  - A reset during a frame abandons the frame. The next start begins again at BASE_ADDR.
//  States
//  - S_IDLE -> S_ACTIVE on start. Pixel count, write count and write address reset to 0 / BASE_ADDR.
//  - S_ACTIVE -> S_DRAIN on the cycle the NUM_PIXELS-th pixel is accepted.
//  - S_DRAIN -> S_DONE on the cycle the NUM_WORDS-th write strobe is issued.
//  - S_DONE: done=1 for exactly one cycle, then the block returns to S_IDLE.
//  Pixel acceptance
//  - pix_ready = (state==S_ACTIVE) && (FIFO free entries >= 2).
//  - A pixel transfers when pix_valid && pix_ready.
//  - Even pixel: push {R,G} and hold B in b_hold.
//  - Odd pixel: push {b_hold,R}, then {G,B}. Both words enter the FIFO in the same cycle, in that order.
//  - The odd-phase flag toggles on every accepted pixel.
//  - Pixels offered in S_IDLE, S_DRAIN or S_DONE are never accepted.
//  SRAM write port
//  - sram_req = FIFO not empty, in S_ACTIVE or S_DRAIN.
//  - At the posedge where sram_req && sram_grant:
//      SRAM_we_n <= 0
//      SRAM_address <= wr_addr
//      SRAM_write_data <= FIFO head
//      pop the FIFO; wr_addr += 1; write count += 1
//  - In every other cycle SRAM_we_n <= 1. Address and data hold their last values.
//  - Latency: the strobe appears 1 cycle after the grant.
//  - Write throughput: 1 word per granted cycle.
//  - Push and pop in the same cycle are legal. Occupancy changes by (pushes - pops).
//  - The FIFO never overflows because pix_ready requires 2 free entries.
//  - An empty FIFO never produces a write.
//  Address range
//  - Writes cover exactly BASE_ADDR .. BASE_ADDR+NUM_WORDS-1 (146944..262143 with defaults).
//  - Each address is written exactly once per frame. No address below BASE_ADDR is ever written.
//  - wr_addr is 18 bits. The final address must not exceed 262143; the parameters must satisfy this.
//  - start during busy=1 is ignored.
//  - done and busy fall together when the block returns to S_IDLE.
// TESTING
//  1. NUM_PIXELS=2, grant tied 1, pixels (11,22,33), (44,55,66)
//     -> 0x1122@146944, 0x3344@146945, 0x5566@146946 on consecutive cycles; done pulses once.
//  2. sram_grant held 0 for 20 cycles, pix_valid held 1
//     -> pix_ready drops once FIFO free < 2; no SRAM_we_n low; all words appear in order after the grant returns.
//  3. Default parameters, random pix_valid and random 50% grant
//     -> exactly 115200 strobes; every address 146944..262143 written once; data matches the packed golden RGB.
//  4. Reset asserted at the 1000th write
//     -> SRAM_we_n=1 and busy=0 with no clock edge; after a new start the first write goes to 146944.
//  5. start pulsed during S_ACTIVE, and pix_valid=1 in S_IDLE
//     -> the start is ignored; pix_ready=0 in S_IDLE; no pixel consumed; write count unaffected.
//  6. Last pixel accepted in the same cycle a pop occurs
//     -> the FIFO count stays correct; S_DRAIN is entered; the final word goes to address BASE_ADDR+NUM_WORDS-1.

Source files
------------

// File: rtl/rgb_sram_writer.sv
// Packs a stream of 8-bit RGB pixels into 16-bit words ({R0,G0},{B0,R1},{G1,B1})
// and writes them sequentially into the RGB region of external SRAM through a small word FIFO.
module rgb_sram_writer #(
    parameter int BASE_ADDR  = 146944,
    parameter int NUM_PIXELS = 76800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic [7:0]  i_pix_r,
    input  logic [7:0]  i_pix_g,
    input  logic [7:0]  i_pix_b,
    output logic        o_sram_req,
    input  logic        i_sram_grant,
    output logic [17:0] o_sram_address,
    output logic [15:0] o_sram_write_data,
    output logic        o_sram_we_n,
    output logic        o_busy,
    output logic        o_done
);

    localparam int NUM_WORDS = 3 * NUM_PIXELS / 2;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PCW = $clog2(NUM_PIXELS + 1);
    localparam int WCW = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [15:0]     r_fifo [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [PCW-1:0]  r_pix_cnt;
    logic [WCW-1:0]  r_wr_cnt;
    logic [17:0]     r_wr_addr;
    logic            r_odd;
    logic [7:0]      r_b_hold;

    logic [17:0]     r_sram_address;
    logic [15:0]     r_sram_write_data;
    logic            r_sram_we_n;

    logic            w_room;
    logic            w_accept;
    logic            w_pop;
    logic [1:0]      w_push_cnt;
    logic [PW-1:0]   w_wr_ptr_p1;
    logic [15:0]     w_word0;
    logic [15:0]     w_word1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An odd pixel pushes two words at once, so acceptance needs two free slots.
    assign w_room      = (r_count <= CW'(FIFO_DEPTH - 2));
    assign w_accept    = i_pix_valid && o_pix_ready;
    assign w_pop       = o_sram_req && i_sram_grant;
    assign w_push_cnt  = w_accept ? (r_odd ? 2'd2 : 2'd1) : 2'd0;
    assign w_wr_ptr_p1 = ptr_inc(r_wr_ptr);
    assign w_word0     = r_odd ? {r_b_hold, i_pix_r} : {i_pix_r, i_pix_g};
    assign w_word1     = {i_pix_g, i_pix_b};

    assign o_sram_address    = r_sram_address;
    assign o_sram_write_data = r_sram_write_data;
    assign o_sram_we_n       = r_sram_we_n;

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_word0;
            if (r_odd) begin
                r_fifo[w_wr_ptr_p1] <= w_word1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_odd ? ptr_inc(w_wr_ptr_p1) : w_wr_ptr_p1;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_pix_cnt         <= '0;
            r_wr_cnt          <= '0;
            r_wr_addr         <= 18'(BASE_ADDR);
            r_odd             <= 1'b0;
            r_b_hold          <= '0;
            r_sram_address    <= '0;
            r_sram_write_data <= '0;
            r_sram_we_n       <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_sram_we_n <= ~w_pop;
            if (r_state == S_IDLE && i_start) begin
                r_pix_cnt <= '0;
                r_wr_cnt  <= '0;
                r_wr_addr <= 18'(BASE_ADDR);
                r_odd     <= 1'b0;
            end
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
                r_odd     <= ~r_odd;
                if (!r_odd) begin
                    r_b_hold <= i_pix_b;
                end
            end
            if (w_pop) begin
                r_sram_address    <= r_wr_addr;
                r_sram_write_data <= r_fifo[r_rd_ptr];
                r_wr_addr         <= r_wr_addr + 18'd1;
                r_wr_cnt          <= r_wr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_pix_ready  = 1'b0;
        o_sram_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                o_pix_ready = w_room;
                o_sram_req  = (r_count != '0);
                if (w_accept && r_pix_cnt == PCW'(NUM_PIXELS - 1)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_sram_req = (r_count != '0);
                if (w_pop && r_wr_cnt == WCW'(NUM_WORDS - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
